// File: rtl/lcd_message_arbiter.sv
// Round-robin arbiter that picks one message requester at a time and sequences
// the LCD controller through a start strobe, a draw window and an on-screen
// hold period before accepting the next request.
module lcd_message_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int START_CYCLES = 1600000,
    parameter int DRAW_CYCLES  = 144000000,
    parameter int HOLD_CYCLES  = 100000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   msg_id,
    output logic [2:0]             message_select,
    output logic                   ready_o,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DRAW  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam int MAX_SD = (START_CYCLES > DRAW_CYCLES) ? START_CYCLES : DRAW_CYCLES;
    localparam int MAX_C  = (MAX_SD > HOLD_CYCLES) ? MAX_SD : HOLD_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C) + 1;
    localparam int PTR_W  = $clog2(NUM_REQ);

    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAW_LOAD  = CNT_W'(DRAW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [PTR_W:0]   NUM_REQ_W  = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REQ - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] rr_ptr;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W:0]   probe;

    // Search upward from rr_ptr, wrapping at NUM_REQ-1, for the first active request.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        probe     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (probe >= NUM_REQ_W) begin
                probe = probe - NUM_REQ_W;
            end
            if (!win_found && req[probe[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = probe[PTR_W-1:0];
            end
        end
        next_ptr = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
    end

    // Sequencer: one shared down-counter times START, DRAW and HOLD in turn.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            rr_ptr         <= '0;
            grant          <= '0;
            message_select <= 3'b000;
        end else begin
            grant <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state          <= START;
                        cnt            <= START_LOAD;
                        grant          <= NUM_REQ'(1) << win_idx;
                        message_select <= msg_id[3*int'(win_idx) +: 3];
                        rr_ptr         <= next_ptr;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        state <= DRAW;
                        cnt   <= DRAW_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DRAW: begin
                    if (cnt == '0) begin
                        state <= HOLD;
                        cnt   <= HOLD_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decode directly from the state so they clear with it on reset.
    always_comb begin
        ready_o = (state == START);
        busy    = (state != IDLE);
        done    = (state == HOLD) && (cnt == '0);
    end

endmodule

// File: tb/tb_lcd_message_arbiter.sv
// Self-checking bench for lcd_message_arbiter with short cycle parameters.
module tb_lcd_message_arbiter;

    localparam int S = 2;
    localparam int D = 5;
    localparam int H = 3;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] msg_id;
    logic [2:0]  message_select;
    logic        ready_o;
    logic [3:0]  grant;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    // Reference model state: round-robin pointer and the message index on screen.
    int         ptr     = 0;
    logic [2:0] exp_sel = 3'b000;

    lcd_message_arbiter #(
        .NUM_REQ(4),
        .START_CYCLES(S),
        .DRAW_CYCLES(D),
        .HOLD_CYCLES(H)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .msg_id(msg_id),
        .message_select(message_select),
        .ready_o(ready_o),
        .grant(grant),
        .busy(busy),
        .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (!$onehot0(grant)) begin
                failures++;
                $display("FAIL inv_onehot grant=%b required one-hot or zero", grant);
            end
            checks++;
            if (ready_o && !(busy && !done)) begin
                failures++;
                $display("FAIL inv_ready ready_o=1 busy=%b done=%b required busy=1 done=0", busy, done);
            end
            checks++;
            if (done && !(busy && !ready_o)) begin
                failures++;
                $display("FAIL inv_done done=1 busy=%b ready_o=%b required busy=1 ready_o=0", busy, ready_o);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    // One full message: request applied at an idle negedge, then the whole
    // START/DRAW/HOLD timeline checked cycle by cycle against the model.
    task automatic serve(input string tag, input logic [3:0] r, input logic [11:0] ids,
                         input bit scramble, input logic [3:0] nxt);
        int w;
        logic [3:0] eg;
        logic [3:0] e_grant;
        logic e_ready, e_busy, e_done;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (ptr + k) % 4;
            if (w < 0 && r[i]) w = i;
        end
        eg      = 4'b0001 << w;
        exp_sel = ids[3*w +: 3];
        req     = r;
        msg_id  = ids;
        for (int c = 1; c <= S + D + H + 1; c++) begin
            @(negedge clk);
            e_grant = (c == 1) ? eg : 4'b0000;
            e_ready = (c <= S);
            e_busy  = (c <= S + D + H);
            e_done  = (c == S + D + H);
            checks++;
            if (grant !== e_grant) begin
                failures++;
                $display("FAIL %s_grant cycle=%0d got=%b exp=%b", tag, c, grant, e_grant);
            end
            checks++;
            if (ready_o !== e_ready) begin
                failures++;
                $display("FAIL %s_ready cycle=%0d got=%b exp=%b", tag, c, ready_o, e_ready);
            end
            checks++;
            if (busy !== e_busy) begin
                failures++;
                $display("FAIL %s_busy cycle=%0d got=%b exp=%b", tag, c, busy, e_busy);
            end
            checks++;
            if (done !== e_done) begin
                failures++;
                $display("FAIL %s_done cycle=%0d got=%b exp=%b", tag, c, done, e_done);
            end
            checks++;
            if (message_select !== exp_sel) begin
                failures++;
                $display("FAIL %s_msel cycle=%0d got=%0d exp=%0d", tag, c, message_select, exp_sel);
            end
            if (c <= S) begin
                req    = scramble ? 4'($urandom) : r;
                msg_id = scramble ? 12'($urandom) : ids;
            end else begin
                req    = nxt;
                msg_id = scramble ? 12'($urandom) : ids;
            end
        end
        ptr = (w + 1) % 4;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        req    = 4'b0000;
        msg_id = 12'h000;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready_o, busy, done, grant, message_select} !== 10'b0) begin
            failures++;
            $display("FAIL reset_state ready=%b busy=%b done=%b grant=%b msel=%0d exp all zero",
                     ready_o, busy, done, grant, message_select);
        end
        reset   = 1'b0;
        ptr     = 0;
        exp_sel = 3'b000;
    endtask

    task automatic test_idle();
        req    = 4'b0000;
        msg_id = 12'($urandom);
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || grant !== 4'b0000 || ready_o !== 1'b0) begin
                failures++;
                $display("FAIL idle_stay busy=%b grant=%b ready=%b exp 0", busy, grant, ready_o);
            end
            checks++;
            if (message_select !== exp_sel) begin
                failures++;
                $display("FAIL idle_msel got=%0d exp=%0d", message_select, exp_sel);
            end
        end
    endtask

    task automatic test_single();
        serve("single", 4'b0001, {9'h1FF, 3'b101}, 1'b0, 4'b0000);
        checks++;
        if (message_select !== 3'd5) begin
            failures++;
            $display("FAIL single_msel5 got=%0d exp=5", message_select);
        end
    endtask

    task automatic test_late_request();
        serve("late_a", 4'b0010, 12'($urandom), 1'b1, 4'b0100);
        serve("late_b", 4'b0100, 12'($urandom), 1'b0, 4'b0000);
    endtask

    task automatic test_wrap();
        serve("wrap_3", 4'b1000, 12'($urandom), 1'b0, 4'b0000);
        serve("wrap_1001", 4'b1001, 12'($urandom), 1'b0, 4'b0000);
        checks++;
        if (ptr != 1) begin
            failures++;
            $display("FAIL wrap_model ptr=%0d exp=1", ptr);
        end
    endtask

    task automatic test_reset_mid_start();
        req    = 4'b0001;
        msg_id = 12'b000_000_000_110;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001 || ready_o !== 1'b1 || message_select !== 3'd6) begin
            failures++;
            $display("FAIL midrst_pre grant=%b ready=%b msel=%0d exp 0001 1 6",
                     grant, ready_o, message_select);
        end
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        checks++;
        if ({ready_o, busy, done, grant, message_select} !== 10'b0) begin
            failures++;
            $display("FAIL midrst_post ready=%b busy=%b done=%b grant=%b msel=%0d exp all zero",
                     ready_o, busy, done, grant, message_select);
        end
        reset   = 1'b0;
        ptr     = 0;
        exp_sel = 3'b000;
        serve("midrst_0010", 4'b0010, 12'($urandom), 1'b0, 4'b0000);
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 5; i++) begin
            serve("rr", 4'b1111, 12'($urandom), 1'b0, (i < 4) ? 4'b1111 : 4'b0000);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(1, 15));
            serve("rand", r, 12'($urandom), 1'b1, 4'b0000);
        end
    endtask

    initial begin
        reset  = 1'b1;
        req    = 4'b0000;
        msg_id = 12'h000;
        test_reset();
        test_idle();
        test_single();
        test_idle();
        test_late_request();
        test_wrap();
        test_reset_mid_start();
        test_reset();
        test_round_robin();
        test_random();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
